mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequences one single-ported, variable-latency memory between the instruction-fetch port and the data port of the five-stage pipeline. It also generates the fetch and memory-stage stall signals that hold the pipeline registers while an access is outstanding. It traps misaligned addresses and unresponsive memory as errors; the pipeline converts these into a halt at MEM/WB. A sticky halt blocks all further grants.

## Interface
Parameters:
- TIMEOUT, 255: cycles to wait for `mem_done` before aborting with error (1..255).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active high.
- `if_req`  in  1  fetch request; level, held until `if_done`.
- `if_addr`  in  16  fetch address.
- `if_rdata`  out  16  fetched instruction; valid when `if_done`.
- `if_done`  out  1  one-cycle completion pulse for fetch.
- `if_err`  out  1  qualifies `if_done`: misaligned or timed out.
- `d_rd`, `d_wr`  in  1  data read / write request; level, held until `d_done`; both high means write.
- `d_addr`, `d_wdata`  in  16  data address and write data.
- `d_rdata`  out  16  load data; valid when `d_done` and read.
- `d_done`, `d_err`  out  1  completion pulse and its error qualifier.
- `halt_req`  in  1  halt from MEM/WB.
- `mem_en`, `mem_wr`  out  1  memory access strobe (one cycle) and write select.
- `mem_addr`, `mem_wdata`  out  16  memory address and write data.
- `mem_rdata`  in  16  memory read data; valid with `mem_done`.
- `mem_done`  in  1  memory completion pulse.
- `stall_if`, `stall_mem`  out  1  hold IF/ID and EX/MEM/MEM/WB respectively.
- `halted`  out  1  sticky halt status.

## Operation
- States: IDLE, IF_WAIT, D_WAIT, RESP, HALTED.
- IDLE:
  - If `halted` is set, or `halt_req` is high, go to HALTED.
  - Otherwise pick the winner:
    - Data wins over fetch unless the last grant was data and `if_req` is high; then fetch wins (alternation).
    - Record the winner in `last_grant`.
  - Winner address bit 0 = 1: no memory access; go to RESP with err = 1.
  - Winner aligned: pulse `mem_en` this cycle and drive `mem_addr`/`mem_wr`/`mem_wdata` from the winner. Go to IF_WAIT or D_WAIT.
- IF_WAIT / D_WAIT:
  - `mem_en` is low.
  - On `mem_done`: capture `mem_rdata` into the response register and go to RESP with err = 0.
  - If `tmo_cnt` reaches TIMEOUT without `mem_done`: go to RESP with err = 1 and response data 0x0000.
  - `tmo_cnt` is an 8-bit counter. It clears on every grant and increments each wait cycle, with no wrap.
- RESP:
  - Pulse `if_done`/`if_err` or `d_done`/`d_err` for the owner, with the registered data.
  - Then go to IDLE.
- `halt_req` seen in any state sets a pending flag. The in-flight access completes normally, then the block enters HALTED instead of granting.
- HALTED: no grants, no done pulses. `halted` = 1. `stall_if` = `if_req` and `stall_mem` = `d_rd|d_wr`. Exit only via `rst`.
- Combinational outputs:
  - `stall_if = if_req & ~if_done`
  - `stall_mem = (d_rd|d_wr) & ~d_done`
- A late `mem_done` arriving in IDLE or RESP is ignored.

## Timing
- Reset values:
  - State = IDLE.
  - `halted`, the halt-pending flag, `last_grant` (= fetch), `tmo_cnt`, and the response data register all clear to 0.
  - All outputs are 0, except the stalls, which follow the request inputs.
- Latency, request high in IDLE at cycle 0:
  - `mem_en` at cycle 0.
  - `mem_done` at cycle N (N ≥ 1).
  - Done pulse at cycle N+1.
  - Earliest next grant at cycle N+2.
- Misaligned request: done + err at cycle 1; no `mem_en`.
- Timeout: done + err at cycle TIMEOUT+1.
- Simultaneous `mem_done` and timeout in the same cycle: `mem_done` wins, err = 0.
- `rst` mid-access: the block returns to IDLE next cycle with no done pulse. The memory's stale `mem_done` is ignored.

## Test plan
- Data read `d_addr`=0x0010, memory returns 0xBEEF after 3 cycles:
  - `mem_en`=1, `mem_wr`=0 at cycle 0.
  - `d_done`=1, `d_rdata`=0xBEEF at cycle 4.
  - `stall_mem`=1 for cycles 0–3.
- `if_req` and `d_wr` high together, both held:
  - Grant order is data, then fetch, then data.
  - `if_done` occurs before the second data grant.
- `if_addr`=0x0003:
  - `if_done`=1 and `if_err`=1 at cycle 1.
  - `mem_en` never asserts.
- TIMEOUT=4 and memory never responds:
  - `d_done`=1, `d_err`=1, `d_rdata`=0x0000 at cycle 5.
  - Next access is granted normally.
- `halt_req` pulsed during D_WAIT:
  - The access completes with `d_done`.
  - `halted`=1 thereafter.
  - Pending `if_req` never receives `mem_en`; `stall_if` stays 1.
- `rst` asserted in IF_WAIT:
  - The block is in IDLE next cycle.
  - No `if_done` pulse.
  - A `mem_done` one cycle later produces no response.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between the fetch and data ports.
// Also produces the pipeline stalls, error responses and a sticky halt.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  output logic        if_err,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  input  logic        halt_req,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_IF_WAIT = 3'd1,
    S_D_WAIT  = 3'd2,
    S_RESP    = 3'd3,
    S_HALTED  = 3'd4
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        halted_q, halted_d;
  logic        halt_pend_q, halt_pend_d;
  logic        last_grant_q, last_grant_d;  // 1 = data port
  logic        owner_q, owner_d;            // 1 = data port
  logic        resp_err_q, resp_err_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic [15:0] resp_data_q, resp_data_d;

  logic        data_req;
  logic        win_data;
  logic [15:0] win_addr;

  assign data_req = d_rd | d_wr;
  // Data normally wins; fetch gets the slot right after a data grant.
  assign win_data = data_req & ~(last_grant_q & if_req);
  assign win_addr = win_data ? d_addr : if_addr;

  always_comb begin
    state_d      = state_q;
    halted_d     = halted_q;
    halt_pend_d  = halt_pend_q | halt_req;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    resp_err_d   = resp_err_q;
    tmo_cnt_d    = tmo_cnt_q;
    resp_data_d  = resp_data_q;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = 16'h0000;
    mem_wdata    = 16'h0000;

    case (state_q)
      S_IDLE: begin
        if (halted_q || halt_pend_q || halt_req) begin
          state_d  = S_HALTED;
          halted_d = 1'b1;
        end else if (!rst && (data_req || if_req)) begin
          last_grant_d = win_data;
          owner_d      = win_data;
          tmo_cnt_d    = 8'd0;
          if (win_addr[0]) begin
            state_d     = S_RESP;
            resp_err_d  = 1'b1;
            resp_data_d = 16'h0000;
          end else begin
            mem_en    = 1'b1;
            mem_wr    = win_data & d_wr;
            mem_addr  = win_addr;
            mem_wdata = (win_data & d_wr) ? d_wdata : 16'h0000;
            state_d   = win_data ? S_D_WAIT : S_IF_WAIT;
          end
        end
      end
      S_IF_WAIT, S_D_WAIT: begin
        if (tmo_cnt_q != 8'hFF) tmo_cnt_d = tmo_cnt_q + 8'd1;
        // A completion in the same cycle as the timeout still counts as success.
        if (mem_done) begin
          state_d     = S_RESP;
          resp_err_d  = 1'b0;
          resp_data_d = mem_rdata;
        end else if (tmo_cnt_q >= TMO_LAST) begin
          state_d     = S_RESP;
          resp_err_d  = 1'b1;
          resp_data_d = 16'h0000;
        end
      end
      S_RESP:   state_d = S_IDLE;
      S_HALTED: halted_d = 1'b1;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      halted_q     <= 1'b0;
      halt_pend_q  <= 1'b0;
      last_grant_q <= 1'b0;
      owner_q      <= 1'b0;
      resp_err_q   <= 1'b0;
      tmo_cnt_q    <= 8'd0;
      resp_data_q  <= 16'h0000;
    end else begin
      state_q      <= state_d;
      halted_q     <= halted_d;
      halt_pend_q  <= halt_pend_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      resp_err_q   <= resp_err_d;
      tmo_cnt_q    <= tmo_cnt_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign if_done   = (state_q == S_RESP) & ~owner_q;
  assign if_err    = if_done & resp_err_q;
  assign if_rdata  = if_done ? resp_data_q : 16'h0000;
  assign d_done    = (state_q == S_RESP) & owner_q;
  assign d_err     = d_done & resp_err_q;
  assign d_rdata   = d_done ? resp_data_q : 16'h0000;
  assign halted    = halted_q;
  assign stall_if  = if_req & ~if_done;
  assign stall_mem = data_req & ~d_done;

endmodule
